// File: rtl/voq_pkg.sv
// Shared types for the VOQ command scheduler and its round-robin arbiter.
package voq_pkg;
  localparam int NVOQ_MAX = 16;

  typedef logic [71:0] voq_cmd_t;
  typedef logic [3:0]  voq_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } sched_state_e;
endpackage

// File: rtl/voq_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW:0] sum;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!gnt_any && req[sum[IW-1:0]]) begin
        gnt_any               = 1'b1;
        gnt_oh[sum[IW-1:0]]   = 1'b1;
        gnt_idx               = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/voq_cmd_scheduler.sv
// Credit-gated round-robin drain of FWFT VOQ command FIFOs into one valid/ready stream.
module voq_cmd_scheduler
  import voq_pkg::*;
#(
  parameter int NVOQ        = 8,
  parameter int WIDTH       = 72,
  parameter int CW          = 4,
  parameter int INIT_CREDIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NVOQ-1:0]          voq_empty,
  input  logic [NVOQ*WIDTH-1:0]    voq_dout,
  input  logic [NVOQ-1:0]          voq_sberr,
  input  logic [NVOQ-1:0]          voq_dberr,
  output logic [NVOQ-1:0]          voq_re,
  input  logic [NVOQ-1:0]          voq_en,
  input  logic [NVOQ-1:0]          credit_ret,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [WIDTH-1:0]         cmd_data,
  output logic [$clog2(NVOQ)-1:0]  cmd_voq,
  output logic [15:0]              sberr_cnt,
  output logic [15:0]              dberr_cnt,
  output logic                     dberr_pulse
);

  localparam int IW = (NVOQ > 1) ? $clog2(NVOQ) : 1;
  localparam logic [CW-1:0] CMAX  = '1;
  localparam logic [CW-1:0] CINIT = CW'(INIT_CREDIT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CW-1:0] sat_inc_cred(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  sched_state_e    state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NVOQ-1:0] holdoff_q, holdoff_d;
  logic [CW-1:0]   credit_q [NVOQ];
  logic [CW-1:0]   credit_d [NVOQ];
  logic [WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [IW-1:0]   cmd_voq_q, cmd_voq_d;
  logic [15:0]     sberr_cnt_q, sberr_cnt_d;
  logic [15:0]     dberr_cnt_q, dberr_cnt_d;
  logic            dberr_pulse_q, dberr_pulse_d;

  logic [NVOQ-1:0] eligible, gnt_oh, pop, consume;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NVOQ; i++)
      eligible[i] = !voq_empty[i] && voq_en[i] && (credit_q[i] != '0) && !holdoff_q[i];
  end

  rr_arbiter #(.N(NVOQ), .IW(IW)) u_arb (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    holdoff_d     = holdoff_q;
    cmd_data_d    = cmd_data_q;
    cmd_voq_d     = cmd_voq_q;
    sberr_cnt_d   = sberr_cnt_q;
    dberr_cnt_d   = dberr_cnt_q;
    dberr_pulse_d = 1'b0;
    pop           = '0;
    consume       = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          pop       = gnt_oh;
          rr_ptr_d  = (int'(gnt_idx) == NVOQ-1) ? '0 : gnt_idx + IW'(1);
          holdoff_d = gnt_oh;
          if (voq_dberr[gnt_idx]) begin
            dberr_cnt_d   = sat_inc16(dberr_cnt_q);
            dberr_pulse_d = 1'b1;
          end else begin
            if (voq_sberr[gnt_idx]) sberr_cnt_d = sat_inc16(sberr_cnt_q);
            consume    = gnt_oh;
            cmd_data_d = voq_dout[int'(gnt_idx)*WIDTH +: WIDTH];
            cmd_voq_d  = gnt_idx;
            state_d    = VALID;
          end
        end else begin
          holdoff_d = '0;
        end
      end
      VALID: begin
        // holdoff is kept through VALID; the FIFO flags have settled by handshake time
        if (cmd_ready) begin
          state_d   = IDLE;
          holdoff_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NVOQ; i++) begin
      credit_d[i] = credit_q[i];
      if (consume[i] && !credit_ret[i])
        credit_d[i] = credit_q[i] - CW'(1);
      else if (credit_ret[i] && !consume[i])
        credit_d[i] = sat_inc_cred(credit_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      holdoff_q     <= '0;
      cmd_data_q    <= '0;
      cmd_voq_q     <= '0;
      sberr_cnt_q   <= '0;
      dberr_cnt_q   <= '0;
      dberr_pulse_q <= 1'b0;
      for (int i = 0; i < NVOQ; i++) credit_q[i] <= CINIT;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      holdoff_q     <= holdoff_d;
      cmd_data_q    <= cmd_data_d;
      cmd_voq_q     <= cmd_voq_d;
      sberr_cnt_q   <= sberr_cnt_d;
      dberr_cnt_q   <= dberr_cnt_d;
      dberr_pulse_q <= dberr_pulse_d;
      for (int i = 0; i < NVOQ; i++) credit_q[i] <= credit_d[i];
    end
  end

  // Pops are suppressed while reset is held so no FIFO word is consumed in reset
  assign voq_re      = pop & {NVOQ{~rst}};
  assign cmd_valid   = (state_q == VALID);
  assign cmd_data    = cmd_data_q;
  assign cmd_voq     = cmd_voq_q;
  assign sberr_cnt   = sberr_cnt_q;
  assign dberr_cnt   = dberr_cnt_q;
  assign dberr_pulse = dberr_pulse_q;

endmodule
